// File: rtl/uart_prog_loader_pkg.sv
// uart_prog_loader_pkg: shared state encodings, frame constants and baud helper
// for the UART program loader and its byte receiver.
package uart_prog_loader_pkg;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam int CSUM_W = 8;

    typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_ADR0, S_ADR1, S_DATA, S_CSUM} ld_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic int bit_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction
endpackage

// File: rtl/uart_prog_loader_if.sv
// uart_prog_loader_if: serial input plus instruction-memory write port and status
// strobes of the loader; master is the loader, slave is the memory/host side.
interface uart_prog_loader_if;
    logic        phyrx;
    logic        w_en;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic        hold_core;
    logic        done;
    logic        err;

    modport master (input phyrx, output w_en, w_addr, w_data, hold_core, done, err);
    modport slave (output phyrx, input w_en, w_addr, w_data, hold_core, done, err);
endinterface

// File: rtl/uart_prog_loader_rx.sv
// uart_rx_byte: 8N1 receiver with 2-flop synchronizer, mid-bit sampling and
// start-bit glitch rejection; pulses valid_o on a good stop bit, ferr_o otherwise.
module uart_rx_byte
    import uart_prog_loader_pkg::*;
#(
    parameter int BIT_DIV = 69
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       ferr_o
);
    localparam int CW = $clog2(BIT_DIV);
    localparam logic [CW-1:0] HALF = CW'(BIT_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BIT_DIV - 1);

    rx_state_t     st_q, st_d;
    logic [2:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          valid_q, valid_d, ferr_q, ferr_d;
    logic          rx_s, fall;

    // sync_q[1] is the synchronized line, sync_q[2] its previous value for edge detect
    assign rx_s = sync_q[1];
    assign fall = sync_q[2] & ~sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= RX_IDLE;
            sync_q  <= 3'b111;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            sync_q  <= {sync_q[1:0], rx_i};
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (st_q)
            RX_IDLE: begin
                cnt_d = '0;
                st_d  = fall ? RX_START : RX_IDLE;
            end
            RX_START: if (cnt_q == HALF) begin
                cnt_d = '0;
                bit_d = '0;
                st_d  = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == FULL) begin
                cnt_d = '0;
                sh_d  = {rx_s, sh_q[7:1]};
                bit_d = bit_q + 3'd1;
                st_d  = (bit_q == 3'd7) ? RX_STOP : RX_DATA;
            end
            RX_STOP: if (cnt_q == FULL) begin
                cnt_d   = '0;
                st_d    = RX_IDLE;
                valid_d = rx_s;
                ferr_d  = ~rx_s;
            end
            default: st_d = RX_IDLE;
        endcase
    end

    assign byte_o  = sh_q;
    assign valid_o = valid_q;
    assign ferr_o  = ferr_q;
endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: parses SYNC/LEN/BASE/data/CSUM frames from the UART and writes
// 32-bit words to instruction memory, holding the core in reset during a load.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int         CLK_HZ         = 8_000_000,
    parameter int         BAUD           = 115_200,
    parameter int         TIMEOUT_CYCLES = 800_000,
    parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT
) (
    input logic                clk,
    input logic                rst,
    uart_prog_loader_if.master bus
);
    localparam int BIT_DIV = bit_div(CLK_HZ, BAUD);
    localparam int GW = $clog2(TIMEOUT_CYCLES);
    localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT_CYCLES - 1);

    ld_state_t         st_q, st_d;
    logic [15:0]       len_q, len_d, base_q, base_d, idx_q, idx_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [23:0]       word_q, word_d;
    logic [CSUM_W-1:0] sum_q, sum_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              w_en_q, w_en_d, done_q, done_d, err_q, err_d;
    logic [31:0]       w_addr_q, w_addr_d, w_data_q, w_data_d;
    logic [7:0]        rx_byte;
    logic              rx_valid, rx_ferr, abort;

    uart_rx_byte #(.BIT_DIV(BIT_DIV)) u_rx (
        .clk     (clk),
        .rst     (rst),
        .rx_i    (bus.phyrx),
        .byte_o  (rx_byte),
        .valid_o (rx_valid),
        .ferr_o  (rx_ferr)
    );

    // a byte arriving on the timeout cycle keeps the frame alive
    assign abort = (st_q != S_IDLE) && !rx_valid && (rx_ferr || gap_q == GAP_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q     <= S_IDLE;
            len_q    <= '0;
            base_q   <= '0;
            idx_q    <= '0;
            bidx_q   <= '0;
            word_q   <= '0;
            sum_q    <= '0;
            gap_q    <= '0;
            w_en_q   <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            st_q     <= st_d;
            len_q    <= len_d;
            base_q   <= base_d;
            idx_q    <= idx_d;
            bidx_q   <= bidx_d;
            word_q   <= word_d;
            sum_q    <= sum_d;
            gap_q    <= gap_d;
            w_en_q   <= w_en_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        len_d    = len_q;
        base_d   = base_q;
        idx_d    = idx_q;
        bidx_d   = bidx_q;
        word_d   = word_q;
        sum_d    = rx_valid ? sum_q + rx_byte : sum_q;
        gap_d    = (rx_valid || st_q == S_IDLE) ? '0 : gap_q + 1'b1;
        w_en_d   = 1'b0;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (abort) begin
            st_d  = S_IDLE;
            gap_d = '0;
            err_d = 1'b1;
        end else if (rx_valid) begin
            case (st_q)
                S_IDLE: if (rx_byte == SYNC_BYTE) begin
                    st_d  = S_LEN0;
                    sum_d = '0;
                end
                S_LEN0: begin
                    len_d[7:0] = rx_byte;
                    st_d       = S_LEN1;
                end
                S_LEN1: begin
                    len_d[15:8] = rx_byte;
                    st_d        = S_ADR0;
                end
                S_ADR0: begin
                    base_d[7:0] = rx_byte;
                    st_d        = S_ADR1;
                end
                S_ADR1: begin
                    base_d[15:8] = rx_byte;
                    idx_d        = '0;
                    bidx_d       = '0;
                    st_d         = (len_q == 16'd0) ? S_CSUM : S_DATA;
                end
                S_DATA: begin
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        w_en_d   = 1'b1;
                        w_data_d = {rx_byte, word_q};
                        w_addr_d = {14'b0, base_q + idx_q, 2'b00};
                        idx_d    = idx_q + 16'd1;
                        st_d     = (idx_q + 16'd1 == len_q) ? S_CSUM : S_DATA;
                    end else begin
                        word_d[{bidx_q, 3'b000} +: 8] = rx_byte;
                    end
                end
                S_CSUM: begin
                    st_d   = S_IDLE;
                    done_d = (sum_d == '0);
                    err_d  = (sum_d != '0);
                end
                default: st_d = S_IDLE;
            endcase
        end
    end

    assign bus.w_en      = w_en_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.w_data    = w_data_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.hold_core = (st_q != S_IDLE);
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: directed frames over the serial line; expected writes are
// queued when a frame is sent and popped as w_en strobes appear.
module tb_uart_prog_loader;
    import uart_prog_loader_pkg::*;

    localparam int CLK_HZ = 8_000_000;
    localparam int BAUD   = 500_000;
    localparam int TMO    = 1000;
    localparam int BD     = bit_div(CLK_HZ, BAUD);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    wr_t         exp_q[$];
    logic [31:0] pay [0:1];
    int          errors = 0, checks = 0, done_cnt = 0, err_cnt = 0;

    uart_prog_loader_if bus();

    uart_prog_loader #(
        .CLK_HZ         (CLK_HZ),
        .BAUD           (BAUD),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want)
        else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    // scoreboard side: every write strobe must match the oldest queued write
    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (bus.err) err_cnt++;
        if (bus.done || bus.err) check("done_err_exclusive", 64'(bus.done & bus.err), 0);
        if (bus.w_en) begin
            wr_t e;
            check("w_en_with_hold", 64'(bus.hold_core), 1);
            check("write_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("w_addr", 64'(bus.w_addr), 64'(e.addr));
                check("w_data", 64'(bus.w_data), 64'(e.data));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.phyrx = 1'b0;
        idle(BD);
        for (int i = 0; i < 8; i++) begin
            bus.phyrx = b[i];
            idle(BD);
        end
        bus.phyrx = 1'b1;
        idle(BD);
    endtask

    task automatic glitch(input int n);
        bus.phyrx = 1'b0;
        idle(n);
        bus.phyrx = 1'b1;
        idle(2 * BD);
    endtask

    task automatic send_frame(input int len, input logic [15:0] base, input logic [7:0] bad, input bit gl);
        logic [7:0] hdr [4];
        logic [7:0] sum, b;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        sum = 8'h00;
        hdr = '{len[7:0], len[15:8], base[7:0], base[15:8]};
        for (int k = 0; k < len; k++)
            exp_q.push_back(wr_t'{addr: {14'b0, 16'(base + k), 2'b00}, data: pay[k]});
        send_byte(8'hA5);
        check("hold_after_sync", 64'(bus.hold_core), 1);
        if (gl) glitch(BD / 4);
        foreach (hdr[i]) begin
            send_byte(hdr[i]);
            sum += hdr[i];
        end
        for (int k = 0; k < len; k++)
            for (int j = 0; j < 4; j++) begin
                b = pay[k][8*j +: 8];
                send_byte(b);
                sum += b;
            end
        check("hold_before_csum", 64'(bus.hold_core), 1);
        send_byte((8'h00 - sum) ^ bad);
        idle(4);
        check("done_count", 64'(done_cnt - d0), (bad == 8'h00) ? 1 : 0);
        check("err_count", 64'(err_cnt - e0), (bad == 8'h00) ? 0 : 1);
        check("hold_after_csum", 64'(bus.hold_core), 0);
        check("writes_drained", 64'(exp_q.size()), 0);
    endtask

    initial begin
        int d0, e0;
        bus.phyrx = 1'b1;
        idle(5);
        check("rst_outputs", {bus.w_en, bus.done, bus.err, bus.hold_core}, 0);
        check("rst_addr_data", {bus.w_addr, bus.w_data}, 0);
        rst = 1'b0;
        idle(2 * BD);

        // good frame A5 02 00 10 00 EF BE FE CA 78 56 34 12 65, then same with bad CSUM
        pay[0] = 32'hCAFEBEEF;
        pay[1] = 32'h12345678;
        send_frame(2, 16'h0010, 8'h00, 1'b0);
        send_frame(2, 16'h0010, 8'h03, 1'b0);

        // empty frame and word-address wrap
        send_frame(0, 16'hFFFF, 8'h00, 1'b0);
        pay[0] = 32'h0BADF00D;
        pay[1] = 32'h5A5AA5A5;
        send_frame(1, 16'hFFFF, 8'h00, 1'b0);
        send_frame(2, 16'hFFFF, 8'h00, 1'b0);

        // noise before SYNC, glitches idle and mid-frame
        send_byte(8'h00);
        send_byte(8'h5A);
        send_byte(8'hFF);
        glitch(BD / 4);
        check("noise_no_hold", 64'(bus.hold_core), 0);
        pay[0] = 32'h01020304;
        pay[1] = 32'hF0E0D0C0;
        send_frame(2, 16'h0100, 8'h00, 1'b1);

        // inter-byte timeout
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        check("timeout_hold_before", 64'(bus.hold_core), 1);
        idle(TMO + 20);
        check("timeout_err", 64'(err_cnt - e0), 1);
        check("timeout_no_done", 64'(done_cnt - d0), 0);
        check("timeout_hold_after", 64'(bus.hold_core), 0);
        pay[0] = 32'h89ABCDEF;
        send_frame(1, 16'h0200, 8'h00, 1'b0);

        // asynchronous reset during the second byte of a data word
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h11);
        bus.phyrx = 1'b0;
        idle(3 * BD);
        #2 rst = 1'b1;
        #1;
        check("async_rst_strobes", {bus.w_en, bus.done, bus.err, bus.hold_core}, 0);
        check("async_rst_addr_data", {bus.w_addr, bus.w_data}, 0);
        bus.phyrx = 1'b1;
        idle(4);
        rst = 1'b0;
        idle(2 * BD);
        send_byte(8'h33);
        idle(4);
        check("post_rst_idle", 64'(bus.hold_core), 0);
        check("post_rst_no_status", 64'((done_cnt - d0) + (err_cnt - e0)), 0);
        pay[0] = 32'h55AA33CC;
        send_frame(1, 16'h0020, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
